// File: rtl/stream_rr_arbiter.sv
// Round-robin ready/valid arbiter with a per-owner burst allowance and grant lock on stall.
// Define STREAM_RR_ARBITER_OUT_REG_EN to add a stream_register-style output stage.
module stream_rr_arbiter #(
  parameter int unsigned  NumInp   = 4,
  parameter int unsigned  MaxBurst = 1,
  parameter type          T        = logic,
  localparam int unsigned IdxW     = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic [NumInp-1:0]   inp_valid_i,
  output logic [NumInp-1:0]   inp_ready_o,
  input  T     [NumInp-1:0]   inp_data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output T                    data_o,
  output logic [IdxW-1:0]     idx_o
);

  localparam int unsigned    CntW   = $clog2(MaxBurst + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxBurst);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NumInp - 1);

  logic [IdxW-1:0] cur_q, cur_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lidx_q, lidx_d;

  logic [IdxW-1:0] sel;
  logic [IdxW-1:0] cand;
  logic            found;
  logic            arb_valid;
  logic            arb_ready;
  logic            hs;

  // The current owner keeps priority while its burst allowance lasts; otherwise the
  // search starts just after it and visits the owner itself last.
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    if (lock_q) begin
      sel = lidx_q;
    end else if (inp_valid_i[cur_q] && (cnt_q < CntMax)) begin
      sel = cur_q;
    end else begin
      for (int unsigned k = 1; k <= NumInp; k++) begin
        cand = IdxW'((32'(cur_q) + k) % NumInp);
        if (!found && inp_valid_i[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign arb_valid = lock_q | (|inp_valid_i);
  assign hs        = arb_valid & arb_ready;

  always_comb begin
    inp_ready_o      = '0;
    inp_ready_o[sel] = arb_ready;
  end

  always_comb begin
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    lock_d = arb_valid & ~arb_ready;
    lidx_d = sel;
    if (hs) begin
      if (sel == cur_q) begin
        if (cnt_q < CntMax) cnt_d = cnt_q + CntW'(1);
      end else begin
        cur_d = sel;
        cnt_d = CntW'(1);
      end
    end
    if (clr_i) begin
      cur_d  = IdxMax;
      cnt_d  = CntMax;
      lock_d = 1'b0;
      lidx_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q  <= IdxMax;
      cnt_q  <= CntMax;
      lock_q <= 1'b0;
      lidx_q <= '0;
    end else begin
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      lidx_q <= lidx_d;
    end
  end

`ifdef STREAM_RR_ARBITER_OUT_REG_EN
  logic            valid_q;
  T                data_q;
  logic [IdxW-1:0] idx_q;

  assign arb_ready = ready_i | ~valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= T'('0);
      idx_q   <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      data_q  <= T'('0);
      idx_q   <= '0;
    end else if (hs) begin
      valid_q <= 1'b1;
      data_q  <= inp_data_i[sel];
      idx_q   <= sel;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;
`else
  assign arb_ready = ready_i;
  assign valid_o   = arb_valid;
  assign data_o    = inp_data_i[sel];
  assign idx_o     = sel;
`endif

endmodule
